// File: rtl/fb_pkg.sv
// Shared types and default constants for the frame buffer sequencer.
package fb_pkg;

  // Sequencer FSM states
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } fb_state_t;

  // Default parameter values
  localparam int FB_CNT_W   = 4;
  localparam int FB_DEF_LEN = 8;
  localparam int FB_NUM_BUF = 2;

  // Width of a buffer index; a single buffer still gets a 1-bit port
  function automatic int sel_width(input int num_buf);
    return (num_buf > 1) ? $clog2(num_buf) : 1;
  endfunction

endpackage

// File: rtl/fb_buf_rotator.sv
// Buffer-index rotator: steps a modulo-NUM_BUF index on each advance strobe.
module fb_buf_rotator
  import fb_pkg::*;
#(
  parameter int NUM_BUF = FB_NUM_BUF
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           advance,
  output logic [sel_width(NUM_BUF)-1:0]  idx
);

  localparam int SEL_W = sel_width(NUM_BUF);
  localparam logic [SEL_W-1:0] LAST = SEL_W'(NUM_BUF - 1);

  // Index register: wraps back to 0 after the last buffer
  always_ff @(posedge clk) begin
    if (reset) begin
      idx <= '0;
    end else if (advance) begin
      idx <= (idx == LAST) ? '0 : idx + 1'b1;
    end
  end

endmodule

// File: rtl/frame_buffer_sequencer.sv
// Frame buffer sequencer: period counter with free-run/one-shot modes,
// shadowed period length, early pre_pulse and rotating buffer index.
module frame_buffer_sequencer
  import fb_pkg::*;
#(
  parameter int CNT_W   = FB_CNT_W,
  parameter int DEF_LEN = FB_DEF_LEN,
  parameter int NUM_BUF = FB_NUM_BUF
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           en,
  input  logic                           oneshot,
  input  logic                           start,
  input  logic                           len_load,
  input  logic [CNT_W-1:0]               len_in,
  output logic [CNT_W-1:0]               count,
  output logic                           pre_pulse,
  output logic                           wrap_pulse,
  output logic [sel_width(NUM_BUF)-1:0]  buf_sel,
  output logic                           busy
);

  localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);
  localparam logic [CNT_W-1:0] LEN_INIT = CNT_W'(DEF_LEN);

  fb_state_t        state, state_next;
  logic [CNT_W-1:0] count_next;
  logic             pre_next;
  logic [CNT_W-1:0] len_shadow;
  logic [CNT_W-1:0] len_act, len_act_next;
  logic [CNT_W-1:0] load_val;
  logic [CNT_W-1:0] shadow_src;
  logic             wrap;

  // A zero length would give a degenerate period, so it is clamped to 1.
  // A load in the same cycle as a wrap is forwarded straight into len_act.
  assign load_val   = (len_in == '0) ? ONE : len_in;
  assign shadow_src = len_load ? load_val : len_shadow;

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and datapath next values; everything holds while en is low
  always_comb begin
    state_next   = state;
    count_next   = count;
    pre_next     = pre_pulse;
    len_act_next = len_act;
    wrap         = 1'b0;
    if (en) begin
      pre_next = (state == ST_RUN) && (count == len_act - ONE);
      case (state)
        ST_IDLE: begin
          count_next   = '0;
          len_act_next = shadow_src;
          if (!oneshot || start) begin
            state_next = ST_RUN;
          end
        end
        ST_RUN: begin
          if (count == len_act) begin
            wrap         = 1'b1;
            count_next   = '0;
            len_act_next = shadow_src;
            if (oneshot) begin
              state_next = ST_IDLE;
            end
          end else begin
            count_next = count + ONE;
          end
        end
        default: begin
          state_next = ST_IDLE;
        end
      endcase
    end
  end

  // Counter, registered pre_pulse and active length
  always_ff @(posedge clk) begin
    if (reset) begin
      count     <= '0;
      pre_pulse <= 1'b0;
      len_act   <= LEN_INIT;
    end else begin
      count     <= count_next;
      pre_pulse <= pre_next;
      len_act   <= len_act_next;
    end
  end

  // Shadow length register; accepts loads even while en is low
  always_ff @(posedge clk) begin
    if (reset) begin
      len_shadow <= LEN_INIT;
    end else if (len_load) begin
      len_shadow <= load_val;
    end
  end

  fb_buf_rotator #(
    .NUM_BUF (NUM_BUF)
  ) u_rotator (
    .clk     (clk),
    .reset   (reset),
    .advance (wrap),
    .idx     (buf_sel)
  );

  assign wrap_pulse = wrap;
  assign busy       = (state == ST_RUN);

endmodule

// File: tb/tb_frame_buffer_sequencer.sv
// Directed self-checking bench for frame_buffer_sequencer (default and
// wide/three-buffer configurations).
module tb_frame_buffer_sequencer;

  logic       clk = 1'b0;
  logic       reset, en, oneshot, start, len_load;
  logic [3:0] len_in;
  logic [3:0] count;
  logic       pre_pulse, wrap_pulse, busy;
  logic [0:0] buf_sel;

  logic       reset2, en2, oneshot2, start2, len_load2;
  logic [7:0] len_in2;
  logic [7:0] count2;
  logic       pre_pulse2, wrap_pulse2, busy2;
  logic [1:0] buf_sel2;

  int vectors    = 0;
  int miscompares = 0;

  frame_buffer_sequencer #(.CNT_W(4), .DEF_LEN(8), .NUM_BUF(2)) dut (
    .clk(clk), .reset(reset), .en(en), .oneshot(oneshot), .start(start),
    .len_load(len_load), .len_in(len_in), .count(count),
    .pre_pulse(pre_pulse), .wrap_pulse(wrap_pulse), .buf_sel(buf_sel),
    .busy(busy)
  );

  frame_buffer_sequencer #(.CNT_W(8), .DEF_LEN(255), .NUM_BUF(3)) dut2 (
    .clk(clk), .reset(reset2), .en(en2), .oneshot(oneshot2), .start(start2),
    .len_load(len_load2), .len_in(len_in2), .count(count2),
    .pre_pulse(pre_pulse2), .wrap_pulse(wrap_pulse2), .buf_sel(buf_sel2),
    .busy(busy2)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [31:0] obs,
                              input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag, input int c, input int p,
                           input int w, input int b, input int bz);
    #1;
    check_output($sformatf("%s.count", tag), 32'(count), c);
    check_output($sformatf("%s.pre", tag), 32'(pre_pulse), p);
    check_output($sformatf("%s.wrap", tag), 32'(wrap_pulse), w);
    check_output($sformatf("%s.buf", tag), 32'(buf_sel), b);
    check_output($sformatf("%s.busy", tag), 32'(busy), bz);
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; en = 1'b1; oneshot = 1'b0; start = 1'b0;
    len_load = 1'b0; len_in = '0;
    reset2 = 1'b1; en2 = 1'b0; oneshot2 = 1'b0; start2 = 1'b0;
    len_load2 = 1'b0; len_in2 = '0;

    // Reset state and free-run with defaults
    tick();
    tick();
    check_all("rst", 0, 0, 0, 0, 0);
    reset = 1'b0;
    check_all("idle", 0, 0, 0, 0, 0);
    tick();
    for (int i = 0; i < 19; i++) begin
      check_all($sformatf("free%0d", i), i % 9, int'(i % 9 == 8),
                int'(i % 9 == 8), (i / 9) % 2, 1);
      tick();
    end

    // One-shot: a single 9-cycle period, second start ignored
    oneshot = 1'b1;
    apply_reset();
    check_all("os_idle0", 0, 0, 0, 0, 0);
    tick();
    check_all("os_idle1", 0, 0, 0, 0, 0);
    start = 1'b1;
    check_all("os_start", 0, 0, 0, 0, 0);
    tick();
    for (int i = 0; i < 9; i++) begin
      start = (i == 3);
      check_all($sformatf("os%0d", i), i, int'(i == 8), int'(i == 8), 0, 1);
      tick();
    end
    start = 1'b0;
    check_all("os_done0", 0, 0, 0, 1, 0);
    tick();
    check_all("os_done1", 0, 0, 0, 1, 0);

    // Length reload: 8 -> 3 -> 1 (clamped 0) -> 5 (load coincident with wrap)
    oneshot = 1'b0;
    apply_reset();
    tick();
    repeat (4) tick();
    len_load = 1'b1; len_in = 4'd3;
    check_all("ld_c4", 4, 0, 0, 0, 1);
    tick();
    len_load = 1'b0;
    for (int c = 5; c <= 8; c++) begin
      check_all($sformatf("ld8_%0d", c), c, int'(c == 8), int'(c == 8), 0, 1);
      tick();
    end
    for (int c = 0; c <= 3; c++) begin
      len_load = (c == 0); len_in = 4'd0;
      check_all($sformatf("ld3_%0d", c), c, int'(c == 3), int'(c == 3), 1, 1);
      tick();
    end
    len_load = 1'b0;
    for (int p = 0; p < 2; p++) begin
      for (int c = 0; c <= 1; c++) begin
        len_load = (p == 1 && c == 1); len_in = 4'd5;
        check_all($sformatf("ld1_%0d_%0d", p, c), c, int'(c == 1),
                  int'(c == 1), p, 1);
        tick();
      end
    end
    len_load = 1'b0;
    for (int c = 0; c <= 5; c++) begin
      check_all($sformatf("ld5_%0d", c), c, int'(c == 5), int'(c == 5), 0, 1);
      tick();
    end
    check_all("ld5_next", 0, 0, 0, 1, 1);

    // Enable low freezes state but still accepts len_load
    apply_reset();
    tick();
    repeat (4) tick();
    en = 1'b0;
    for (int k = 0; k < 5; k++) begin
      len_load = (k == 0); len_in = 4'd2;
      check_all($sformatf("hold%0d", k), 4, 0, 0, 0, 1);
      tick();
    end
    len_load = 1'b0;
    en = 1'b1;
    check_all("resume4", 4, 0, 0, 0, 1);
    tick();
    check_all("resume5", 5, 0, 0, 0, 1);
    oneshot = 1'b1;
    tick();
    check_all("mid6", 6, 0, 0, 0, 1);
    tick();
    check_all("mid7", 7, 0, 0, 0, 1);
    tick();
    en = 1'b0;
    check_all("hold8a", 8, 1, 0, 0, 1);
    tick();
    check_all("hold8b", 8, 1, 0, 0, 1);
    en = 1'b1;
    check_all("wrap8", 8, 1, 1, 0, 1);
    tick();
    check_all("os_end", 0, 0, 0, 1, 0);
    oneshot = 1'b0;
    tick();
    for (int c = 0; c <= 2; c++) begin
      check_all($sformatf("len2_%0d", c), c, int'(c == 2), int'(c == 2), 1, 1);
      tick();
    end
    check_all("len2_next", 0, 0, 0, 0, 1);

    // Reset mid-period wins over start/len_load
    apply_reset();
    tick();
    repeat (9) tick();
    repeat (2) tick();
    len_load = 1'b1; len_in = 4'd3;
    tick();
    len_load = 1'b0;
    repeat (4) tick();
    check_all("pre_rst", 7, 0, 0, 1, 1);
    reset = 1'b1; len_load = 1'b1; len_in = 4'd1; start = 1'b1;
    tick();
    reset = 1'b0; len_load = 1'b0; start = 1'b0;
    check_all("post_rst", 0, 0, 0, 0, 0);
    tick();
    for (int c = 0; c <= 8; c++) begin
      check_all($sformatf("rst8_%0d", c), c, int'(c == 8), int'(c == 8), 0, 1);
      tick();
    end

    // Wide counter, three buffers, full-range length
    en2 = 1'b1;
    tick();
    reset2 = 1'b0;
    #1;
    check_output("w_idle_busy", 32'(busy2), 0);
    check_output("w_idle_count", 32'(count2), 0);
    tick();
    for (int i = 0; i < 769; i++) begin
      check_output($sformatf("w%0d.count", i), 32'(count2), i % 256);
      check_output($sformatf("w%0d.buf", i), 32'(buf_sel2), (i / 256) % 3);
      check_output($sformatf("w%0d.wrap", i), 32'(wrap_pulse2),
                   int'(i % 256 == 255));
      check_output($sformatf("w%0d.pre", i), 32'(pre_pulse2),
                   int'(i % 256 == 255));
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
